// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: 0x03 read, 0xAB release/device-ID, 0xB9 deep power-down, over a 16-bit word memory.
// Define SPI_FLASH_RESPONDER_FAST_READ_EN to add 0x0B fast read with its 8-bit dummy phase.
module spi_flash_responder #(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] DEVICE_ID  = 8'h40
) (
    input  logic                  cpu_clock,
    input  logic                  reset_n,
    input  logic                  SCK_in,
    input  logic                  CSLow_in,
    input  logic                  MOSI_in,
    output logic                  MISO,
    output logic                  MISO_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    input  logic [15:0]           mem_data,
    output logic                  powered_down
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

    state_t state, next_state;

    logic [1:0]  sck_sync, cs_sync, mosi_sync;
    logic        sck_prev, cs_prev;
    logic        sck_rise, sck_fall, cs_rise, cs_fall, mosi_bit;
    logic [22:0] shift_in;
    logic [4:0]  bit_cnt, dummy_last;
    logic [2:0]  data_bit;
    logic [23:0] byte_addr, next_byte_addr;
    logic [15:0] word;
    logic        read_pending, is_id;
    logic        cmd_done, addr_done, dummy_done, enter_data;
    state_t      decoded;
    logic [7:0]  op_in, cur_byte;
    logic [23:0] addr_in;
    logic [ADDR_WIDTH-1:0] fetch_word;

    // CS being high masks SCK entirely, so idle-bus clocking never reaches the FSM.
    assign sck_rise = sck_sync[1] & ~sck_prev & ~cs_sync[1];
    assign sck_fall = ~sck_sync[1] & sck_prev & ~cs_sync[1];
    assign cs_rise  = cs_sync[1] & ~cs_prev;
    assign cs_fall  = ~cs_sync[1] & cs_prev;
    assign mosi_bit = mosi_sync[1];

    assign op_in          = {shift_in[6:0], mosi_bit};
    assign addr_in        = {shift_in[22:0], mosi_bit};
    assign next_byte_addr = byte_addr + 24'd1;
    assign fetch_word     = addr_done ? addr_in[ADDR_WIDTH:1] : byte_addr[ADDR_WIDTH:1];
    assign cur_byte       = is_id ? DEVICE_ID : (byte_addr[0] ? word[7:0] : word[15:8]);
    assign enter_data     = (next_state == DATA) && (state != DATA);

`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    logic is_fast;
    assign dummy_last = is_fast ? 5'd7 : 5'd23;
`else
    assign dummy_last = 5'd23;
`endif

    always_ff @(posedge cpu_clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        decoded    = IGNORE;
        cmd_done   = 1'b0;
        addr_done  = 1'b0;
        dummy_done = 1'b0;
        if (!powered_down || op_in == 8'hAB) begin
            case (op_in)
                8'h03:   decoded = ADDR;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                8'h0B:   decoded = ADDR;
`endif
                8'hAB:   decoded = DUMMY;
                default: decoded = IGNORE;
            endcase
        end
        case (state)
            IDLE: if (cs_fall) next_state = CMD;
            CMD: if (sck_rise && bit_cnt == 5'd7) begin
                cmd_done   = 1'b1;
                next_state = decoded;
            end
            ADDR: if (sck_rise && bit_cnt == 5'd23) begin
                addr_done = 1'b1;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                next_state = is_fast ? DUMMY : DATA;
`else
                next_state = DATA;
`endif
            end
            DUMMY: if (sck_rise && bit_cnt == dummy_last) begin
                dummy_done = 1'b1;
                next_state = DATA;
            end
            default: ;
        endcase
        if (cs_rise) next_state = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge cpu_clock) begin
        if (!reset_n) begin
            sck_sync     <= '0;
            cs_sync      <= '0;
            mosi_sync    <= '0;
            sck_prev     <= 1'b0;
            cs_prev      <= 1'b0;
            shift_in     <= '0;
            bit_cnt      <= '0;
            data_bit     <= '0;
            byte_addr    <= '0;
            word         <= '0;
            read_pending <= 1'b0;
            is_id        <= 1'b0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
            is_fast      <= 1'b0;
`endif
            MISO         <= 1'b0;
            MISO_enable  <= 1'b0;
            mem_read     <= 1'b0;
            mem_address  <= '0;
            powered_down <= 1'b0;
        end else begin
            sck_sync     <= {sck_sync[0], SCK_in};
            cs_sync      <= {cs_sync[0], CSLow_in};
            mosi_sync    <= {mosi_sync[0], MOSI_in};
            sck_prev     <= sck_sync[1];
            cs_prev      <= cs_sync[1];
            mem_read     <= 1'b0;
            read_pending <= mem_read;
            if (read_pending) word <= mem_data;

            if (cs_rise || cs_fall) begin
                shift_in    <= '0;
                bit_cnt     <= '0;
                data_bit    <= '0;
                MISO        <= 1'b0;
                MISO_enable <= 1'b0;
            end else if (sck_rise && (state inside {CMD, ADDR, DUMMY})) begin
                shift_in <= {shift_in[21:0], mosi_bit};
                bit_cnt  <= (cmd_done || addr_done || dummy_done) ? 5'd0 : bit_cnt + 5'd1;
                if (cmd_done) begin
                    is_id <= (op_in == 8'hAB);
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                    is_fast <= (op_in == 8'h0B);
`endif
                    if (op_in == 8'hB9) powered_down <= 1'b1;
                end
                if (addr_done) byte_addr <= addr_in;
                if (enter_data && is_id) powered_down <= 1'b0;
                if (enter_data && !is_id) begin
                    mem_read    <= 1'b1;
                    mem_address <= fetch_word;
                end
            end else if (sck_fall && state == DATA) begin
                MISO        <= cur_byte[~data_bit];
                MISO_enable <= 1'b1;
                data_bit    <= data_bit + 3'd1;
                // Last bit of a byte is on the wire: advance, and fetch the next word on a word crossing.
                if (data_bit == 3'd7 && !is_id) begin
                    byte_addr <= next_byte_addr;
                    if (byte_addr[0]) begin
                        mem_read    <= 1'b1;
                        mem_address <= next_byte_addr[ADDR_WIDTH:1];
                    end
                end
            end
        end
    end

endmodule
